// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: W stage vs queued long-latency-unit results (optional WBARB_PERF_EN counters).
// Latency: granted write appears on rf_* one clock after the grant cycle.
// Backpressure: lu_ready drops when the LU FIFO is full; stallW holds W for one forced-drain cycle.
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        lu_valid,
    input  logic [4:0]  lu_reg,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stallW,
    output logic [31:0] pend_mask
`ifdef WBARB_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_conflict_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [WW-1:0]   wait_cnt;
    logic [WW-1:0]   wait_next;
    logic            force_q;
    logic            force_next;

    logic            w_req;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            grant;
    entry_t          grant_entry;

    assign w_req      = RegWriteW && (WriteRegW != 5'd0);
    assign fifo_empty = (count == '0);
    assign lu_ready   = (count != FULL);
    // Writes to r0 are accepted to keep the LU moving but never occupy a slot.
    assign push       = lu_valid && lu_ready && (lu_reg != 5'd0);
    assign stallW     = force_q;

    always_comb begin
        pop         = 1'b0;
        grant       = 1'b0;
        grant_entry = '0;
        if (force_q && !fifo_empty) begin
            pop         = 1'b1;
            grant       = 1'b1;
            grant_entry = mem[head];
        end else if (w_req) begin
            grant       = 1'b1;
            grant_entry = '{rd: WriteRegW, data: ResultW};
        end else if (!fifo_empty) begin
            pop         = 1'b1;
            grant       = 1'b1;
            grant_entry = mem[head];
        end
    end

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
        if (pop || fifo_empty) begin
            wait_next = '0;
        end else if (wait_cnt == WAIT_LIM) begin
            wait_next = wait_cnt;
        end else begin
            wait_next = wait_cnt + WW'(1);
        end
        force_next = (count_next == FULL) ||
                     ((count_next != '0) && (wait_next == WAIT_LIM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wait_cnt <= '0;
            force_q  <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            count    <= count_next;
            wait_cnt <= wait_next;
            force_q  <= force_next;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            rf_we <= grant;
            if (grant) begin
                rf_waddr <= grant_entry.rd;
                rf_wdata <= grant_entry.data;
            end
        end
    end

    // Storage needs no reset: only slots inside [head, head+count) are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{rd: lu_reg, data: lu_data};
    end

    always_comb begin
        logic [PW-1:0] offs;
        offs      = '0;
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head;
            if ({1'b0, offs} < count) pend_mask[mem[i].rd] = 1'b1;
        end
    end

`ifdef WBARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (stallW) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (w_req && !fifo_empty && !force_q)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
